// File: rtl/yuv_pkg.sv
// Shared definitions for the 4:2:2 -> 4:4:4 chroma upsampler: neutral chroma
// level and the output-sequencer state encoding.
package yuv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_P0 = 2'd1,
        EMIT_P1 = 2'd2,
        EMIT_S  = 2'd3
    } out_state_t;

    // Mid-scale code for an unsigned chroma component of the given width.
    function automatic int unsigned chroma_mid(input int unsigned dw);
        return 32'd1 << (dw - 32'd1);
    endfunction

    localparam logic [7:0] C_CHROMA_NEUTRAL = 8'(chroma_mid(8));

endpackage

// File: rtl/yuv422_yuv444_if.sv
// Video stream bundle: 4:2:2 input side (sync, valid, luma, muxed chroma)
// and 4:4:4 output side.
interface yuv_if #(
    parameter int DW = 8
);
    logic          i_hs;
    logic          line_end;
    logic          i_de;
    logic [DW-1:0] i_y;
    logic [DW-1:0] i_c;
    logic          o_de;
    logic          o_hs;
    logic [DW-1:0] o_y;
    logic [DW-1:0] o_cb;
    logic [DW-1:0] o_cr;

    modport master (
        output i_hs, line_end, i_de, i_y, i_c,
        input  o_de, o_hs, o_y, o_cb, o_cr
    );

    modport slave (
        input  i_hs, line_end, i_de, i_y, i_c,
        output o_de, o_hs, o_y, o_cb, o_cr
    );
endinterface

// File: rtl/yuv422_yuv444.sv
// 4:2:2 to 4:4:4 converter: captures Cb/Cr pixel pairs and replays each pair
// as two pixels sharing the same chroma; odd line tails reuse the last Cr.
module yuv422_yuv444
    import yuv_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic sys_clk,
    input  logic rst,
    yuv_if.slave vid
);
    localparam logic [DW-1:0] NEUTRAL = DW'(chroma_mid(DW));

    logic          hs_d1_reg, hs_d2_reg;
    logic          phase_reg;
    logic          pair_done_reg, single_done_reg;
    logic [DW-1:0] y0_reg, y1_reg, cb_reg, cr_reg, cr_hold_reg;
    logic [DW-1:0] p1_y_reg, p1_cb_reg, p1_cr_reg;
    logic [DW-1:0] s_y_reg, s_cb_reg, s_cr_reg;
    out_state_t    state_reg, state_next;
    logic          o_de_reg;
    logic [DW-1:0] o_y_reg, o_cb_reg, o_cr_reg;

    logic hs_rise, pix_phase, take_even, take_odd;

    // A line-start edge forces the coincident pixel (if any) to be Cb.
    assign hs_rise   = vid.i_hs & ~hs_d1_reg;
    assign pix_phase = hs_rise ? 1'b0 : phase_reg;
    assign take_even = vid.i_de & ~pix_phase;
    assign take_odd  = vid.i_de & pix_phase;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hs_d1_reg       <= 1'b0;
            hs_d2_reg       <= 1'b0;
            phase_reg       <= 1'b0;
            pair_done_reg   <= 1'b0;
            single_done_reg <= 1'b0;
            y0_reg          <= '0;
            y1_reg          <= '0;
            cb_reg          <= NEUTRAL;
            cr_reg          <= NEUTRAL;
            cr_hold_reg     <= NEUTRAL;
            p1_y_reg        <= '0;
            p1_cb_reg       <= NEUTRAL;
            p1_cr_reg       <= NEUTRAL;
            s_y_reg         <= '0;
            s_cb_reg        <= NEUTRAL;
            s_cr_reg        <= NEUTRAL;
        end else begin
            hs_d1_reg <= vid.i_hs;
            hs_d2_reg <= hs_d1_reg;

            if (vid.i_de)
                phase_reg <= vid.line_end ? 1'b0 : ~pix_phase;
            else if (hs_rise)
                phase_reg <= 1'b0;

            pair_done_reg <= take_odd;
            // A single that lands while the pair ahead of it is still in
            // EMIT_P0 must survive until the sequencer can take it.
            single_done_reg <= (take_even & vid.line_end)
                             | (single_done_reg & (state_reg == EMIT_P0));

            if (take_even) begin
                y0_reg <= vid.i_y;
                cb_reg <= vid.i_c;
            end

            if (take_odd) begin
                y1_reg      <= vid.i_y;
                cr_reg      <= vid.i_c;
                cr_hold_reg <= vid.i_c;
            end else if (hs_rise) begin
                cr_hold_reg <= NEUTRAL;
            end

            // Snapshot the lone tail pixel so a following line cannot clobber it.
            if (take_even & vid.line_end) begin
                s_y_reg  <= vid.i_y;
                s_cb_reg <= vid.i_c;
                s_cr_reg <= hs_rise ? NEUTRAL : cr_hold_reg;
            end

            if (pair_done_reg) begin
                p1_y_reg  <= y1_reg;
                p1_cb_reg <= cb_reg;
                p1_cr_reg <= cr_reg;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMIT_P0: state_next = EMIT_P1;
            IDLE, EMIT_P1, EMIT_S: begin
                if (pair_done_reg)
                    state_next = EMIT_P0;
                else if (single_done_reg)
                    state_next = EMIT_S;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output registers load on the edge that enters each emit state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            o_de_reg <= 1'b0;
            o_y_reg  <= '0;
            o_cb_reg <= NEUTRAL;
            o_cr_reg <= NEUTRAL;
        end else begin
            o_de_reg <= (state_next != IDLE);
            case (state_next)
                EMIT_P0: begin
                    o_y_reg  <= y0_reg;
                    o_cb_reg <= cb_reg;
                    o_cr_reg <= cr_reg;
                end
                EMIT_P1: begin
                    o_y_reg  <= p1_y_reg;
                    o_cb_reg <= p1_cb_reg;
                    o_cr_reg <= p1_cr_reg;
                end
                EMIT_S: begin
                    o_y_reg  <= s_y_reg;
                    o_cb_reg <= s_cb_reg;
                    o_cr_reg <= s_cr_reg;
                end
                default: ;
            endcase
        end
    end

    assign vid.o_de = o_de_reg;
    assign vid.o_hs = hs_d2_reg;
    assign vid.o_y  = o_y_reg;
    assign vid.o_cb = o_cb_reg;
    assign vid.o_cr = o_cr_reg;

endmodule

// File: tb/tb_yuv422_yuv444.sv
// Directed bench for yuv422_yuv444: each step drives one input cycle and
// checks the registered outputs 1 ns after the sampling edge.
module tb_yuv422_yuv444;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    yuv_if #(.DW(8)) vid ();

    yuv422_yuv444 #(.DW(8)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .vid     (vid)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic hs, input logic de, input logic le,
                       input logic [7:0] y, input logic [7:0] c,
                       input logic ede, input logic [7:0] ey,
                       input logic [7:0] ecb, input logic [7:0] ecr,
                       input string tag);
        vid.i_hs     = hs;
        vid.i_de     = de;
        vid.line_end = le;
        vid.i_y      = y;
        vid.i_c      = c;
        @(posedge clk);
        #1;
        $display("step %s: in hs=%0b de=%0b le=%0b y=%02h c=%02h | out de=%0b y=%02h cb=%02h cr=%02h",
                 tag, hs, de, le, y, c, vid.o_de, vid.o_y, vid.o_cb, vid.o_cr);
        chk8({tag, ".de"}, {7'd0, vid.o_de}, {7'd0, ede});
        chk8({tag, ".y"},  vid.o_y,  ey);
        chk8({tag, ".cb"}, vid.o_cb, ecb);
        chk8({tag, ".cr"}, vid.o_cr, ecr);
    endtask

    initial begin
        vid.i_hs = 1'b0; vid.i_de = 1'b0; vid.line_end = 1'b0;
        vid.i_y = 8'h00; vid.i_c = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk8("rst.de", {7'd0, vid.o_de}, 8'h00);
        chk8("rst.hs", {7'd0, vid.o_hs}, 8'h00);
        chk8("rst.y",  vid.o_y,  8'h00);
        chk8("rst.cb", vid.o_cb, 8'h80);
        chk8("rst.cr", vid.o_cr, 8'h80);
        rst = 1'b0;
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h80, 8'h80, "idle");

        // Contiguous 4-pixel line, latency 2, chroma replicated
        cyc(1, 1, 0, 8'h00, 8'h10, 0, 8'h00, 8'h80, 8'h80, "t1_p0");
        chk8("t1_p0.hs", {7'd0, vid.o_hs}, 8'h00);
        cyc(0, 1, 0, 8'h01, 8'h20, 0, 8'h00, 8'h80, 8'h80, "t1_p1");
        chk8("t1_p1.hs", {7'd0, vid.o_hs}, 8'h01);
        cyc(0, 1, 0, 8'h02, 8'h11, 1, 8'h00, 8'h10, 8'h20, "t1_o0");
        chk8("t1_o0.hs", {7'd0, vid.o_hs}, 8'h00);
        cyc(0, 1, 1, 8'h03, 8'h21, 1, 8'h01, 8'h10, 8'h20, "t1_o1");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h02, 8'h11, 8'h21, "t1_o2");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h03, 8'h11, 8'h21, "t1_o3");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h03, 8'h11, 8'h21, "t1_hold");

        // Gapped input, one idle cycle between pixels
        cyc(1, 0, 0, 8'h00, 8'h00, 0, 8'h03, 8'h11, 8'h21, "t2_hs");
        cyc(0, 1, 0, 8'h00, 8'h10, 0, 8'h03, 8'h11, 8'h21, "t2_p0");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h03, 8'h11, 8'h21, "t2_g0");
        cyc(0, 1, 0, 8'h01, 8'h20, 0, 8'h03, 8'h11, 8'h21, "t2_p1");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h10, 8'h20, "t2_o0");
        cyc(0, 1, 0, 8'h02, 8'h11, 1, 8'h01, 8'h10, 8'h20, "t2_o1");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h10, 8'h20, "t2_g2");
        cyc(0, 1, 1, 8'h03, 8'h21, 0, 8'h01, 8'h10, 8'h20, "t2_p3");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h02, 8'h11, 8'h21, "t2_o2");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h03, 8'h11, 8'h21, "t2_o3");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h03, 8'h11, 8'h21, "t2_hold");

        // Odd 3-pixel line, then next line (no hs) must restart at Cb
        cyc(1, 1, 0, 8'h00, 8'h30, 0, 8'h03, 8'h11, 8'h21, "t3_p0");
        cyc(0, 1, 0, 8'h01, 8'h40, 0, 8'h03, 8'h11, 8'h21, "t3_p1");
        cyc(0, 1, 1, 8'h02, 8'h31, 1, 8'h00, 8'h30, 8'h40, "t3_o0");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h01, 8'h30, 8'h40, "t3_o1");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h02, 8'h31, 8'h40, "t3_os");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h02, 8'h31, 8'h40, "t3_hold");
        cyc(0, 1, 0, 8'h04, 8'h50, 0, 8'h02, 8'h31, 8'h40, "t3_n0");
        cyc(0, 1, 1, 8'h05, 8'h60, 0, 8'h02, 8'h31, 8'h40, "t3_n1");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h04, 8'h50, 8'h60, "t3_no0");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h05, 8'h50, 8'h60, "t3_no1");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h05, 8'h50, 8'h60, "t3_nhold");

        // Single-pixel line: Cr falls back to neutral
        cyc(1, 1, 1, 8'h00, 8'h55, 0, 8'h05, 8'h50, 8'h60, "t4_p0");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h55, 8'h80, "t4_os");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h55, 8'h80, "t4_hold");

        // hs edge after half a pair discards it; next pixel is Cb
        cyc(1, 1, 0, 8'h07, 8'h77, 0, 8'h00, 8'h55, 8'h80, "t5_orph");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h55, 8'h80, "t5_g");
        cyc(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h55, 8'h80, "t5_hs");
        cyc(0, 1, 0, 8'h08, 8'h12, 0, 8'h00, 8'h55, 8'h80, "t5_p0");
        cyc(0, 1, 1, 8'h09, 8'h34, 0, 8'h00, 8'h55, 8'h80, "t5_p1");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h08, 8'h12, 8'h34, "t5_o0");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h09, 8'h12, 8'h34, "t5_o1");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h09, 8'h12, 8'h34, "t5_hold");

        // Reset during EMIT_P0 with a half pair pending, then a fresh pair
        cyc(1, 1, 0, 8'h20, 8'h44, 0, 8'h09, 8'h12, 8'h34, "t6_p0");
        cyc(0, 1, 0, 8'h21, 8'h66, 0, 8'h09, 8'h12, 8'h34, "t6_p1");
        cyc(0, 1, 0, 8'h22, 8'h99, 1, 8'h20, 8'h44, 8'h66, "t6_o0");
        rst = 1'b1;
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h80, 8'h80, "t6_rst");
        chk8("t6_rst.hs", {7'd0, vid.o_hs}, 8'h00);
        rst = 1'b0;
        cyc(0, 1, 0, 8'h30, 8'h1a, 0, 8'h00, 8'h80, 8'h80, "t6_n0");
        cyc(0, 1, 1, 8'h31, 8'h2b, 0, 8'h00, 8'h80, 8'h80, "t6_n1");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h30, 8'h1a, 8'h2b, "t6_no0");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h31, 8'h1a, 8'h2b, "t6_no1");
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h31, 8'h1a, 8'h2b, "t6_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
